maq_hm: RTL

- Minutes/hours stage of the digital clock, directly downstream of the seconds counter.
- Consumes the seconds stage's add-minute carry and keeps BCD minutes 00-59 and hours 00-23.
- Provides a button-driven time-set state machine (mode/increment pulses) and a day-rollover pulse.
- Outputs feed the display decoder.

---
 rtl/maq_pkg.sv | 30 +++
 rtl/maq_bcd2.sv | 61 ++++++
 rtl/maq_hm.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/maq_pkg.sv
// Shared types, limits and helpers for the minutes/hours clock stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package maq_pkg;

  // Set-mode state machine. Code 2'b11 is unreachable and is treated as RUN.
  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_SET_H = 2'b01,
    ST_SET_M = 2'b10
  } state_t;

  localparam int LSD_MAX  = 9;   // units digit rolls 9 -> 0
  localparam int MMSD_MAX = 5;   // minutes tens digit never exceeds 5
  localparam int M_MAX    = 59;  // last minute before rollover
  localparam int H24_MAX  = 23;  // last hour in 24h mode
  localparam int H12_MAX  = 12;  // last hour in 12h mode (12 -> 01)
  localparam int H12_MIN  = 1;   // first hour after the 12h wrap
  localparam int H12_PM   = 11;  // 11 -> 12 flips the am/pm flag

  // Decimal 0-99 to two packed BCD digits {tens, units}.
  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] tens;
    logic [3:0] units;
    tens  = 4'(v / 10);
    units = 4'(v % 10);
    return {tens, units};
  endfunction

endpackage

// File: rtl/maq_bcd2.sv
// Two-digit BCD counter that wraps from MAX_VAL back to MIN_VAL.
// Latency: digits update on the edge where inc is high; wrap is a same-cycle carry.
// Backpressure: none; every inc pulse is counted.
//
// Ports: clk/rst_n (async active-low), inc (count one step), load (reload RST_VAL),
//        lsd/msd (registered BCD digits), wrap (inc while at MAX_VAL).
module maq_bcd2
  import maq_pkg::*;
#(
  parameter int MSD_W   = 3,
  parameter int MAX_VAL = 59,
  parameter int MIN_VAL = 0,
  parameter int RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             load,
  output logic [3:0]       lsd,
  output logic [MSD_W-1:0] msd,
  output logic             wrap
);

  localparam logic [7:0] MAX_B = to_bcd(MAX_VAL);
  localparam logic [7:0] MIN_B = to_bcd(MIN_VAL);
  localparam logic [7:0] RST_B = to_bcd(RST_VAL);

  localparam logic [3:0]       MAX_L = MAX_B[3:0];
  localparam logic [MSD_W-1:0] MAX_M = MSD_W'(MAX_B[7:4]);
  localparam logic [3:0]       MIN_L = MIN_B[3:0];
  localparam logic [MSD_W-1:0] MIN_M = MSD_W'(MIN_B[7:4]);
  localparam logic [3:0]       RST_L = RST_B[3:0];
  localparam logic [MSD_W-1:0] RST_M = MSD_W'(RST_B[7:4]);
  localparam logic [3:0]       L_TOP = 4'(LSD_MAX);

  logic at_max;

  assign at_max = (lsd == MAX_L) && (msd == MAX_M);
  assign wrap   = inc && at_max;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lsd <= RST_L;
      msd <= RST_M;
    end else if (load) begin
      lsd <= RST_L;
      msd <= RST_M;
    end else if (inc) begin
      if (at_max) begin
        lsd <= MIN_L;
        msd <= MIN_M;
      end else if (lsd == L_TOP) begin
        lsd <= 4'd0;
        msd <= msd + MSD_W'(1);
      end else begin
        lsd <= lsd + 4'd1;
      end
    end
  end

endmodule

// File: rtl/maq_hm.sv
// Minutes/hours stage: BCD mm:hh from the seconds carry, plus button time-set FSM.
// Latency: digits update on the first edge that sees addminuto high; addday one edge after 23:59->00:00.
// Backpressure: none; one minute per carry rise, mode/inc pulses acted on the edge they are seen.
//
// Ports: maqhm_clock, maqhm_reset (async active-low), maqhm_addminuto (carry level),
//        maqhm_mode / maqhm_inc (one-clock button pulses), BCD digits out, maqhm_state
//        (00 RUN, 01 SET_H, 10 SET_M), maqhm_zerosec and maqhm_addday one-clock pulses.
// Build option: define MAQHM_12H_EN for a 12h clock (12,01..11) with the maqhm_pm output.
module maq_hm
  import maq_pkg::*;
#(
`ifdef MAQHM_12H_EN
  parameter int RST_H = 12,
`else
  parameter int RST_H = 0,
`endif
  parameter int RST_M = 0
) (
  input  logic       maqhm_clock,
  input  logic       maqhm_reset,
  input  logic       maqhm_addminuto,
  input  logic       maqhm_mode,
  input  logic       maqhm_inc,
  output logic [3:0] maqhm_mLsd,
  output logic [2:0] maqhm_mMsd,
  output logic [3:0] maqhm_hLsd,
  output logic [1:0] maqhm_hMsd,
  output logic [1:0] maqhm_state,
`ifdef MAQHM_12H_EN
  output logic       maqhm_pm,
`endif
  output logic       maqhm_zerosec,
  output logic       maqhm_addday
);

  state_t state;
  logic   add_q;      // previous addminuto level, tracked in every state
  logic   minute_ev;
  logic   run;
  logic   m_inc;
  logic   m_wrap;
  logic   h_inc;
  logic   h_wrap;
  logic   day_ev;
  logic   day_q;      // delays addday one edge behind the digit rollover

  assign minute_ev = maqhm_addminuto && !add_q;
  // Anything other than the two set states behaves as RUN, including code 11.
  assign run       = (state != ST_SET_H) && (state != ST_SET_M);

  // Minute carry only ripples into the hour while running; in SET_M the
  // minute wraps 59->00 on its own.
  assign m_inc = (run && minute_ev) || ((state == ST_SET_M) && maqhm_inc);
  assign h_inc = (run && m_wrap)    || ((state == ST_SET_H) && maqhm_inc);

  maq_bcd2 #(
    .MSD_W   (3),
    .MAX_VAL (M_MAX),
    .MIN_VAL (0),
    .RST_VAL (RST_M)
  ) u_min (
    .clk   (maqhm_clock),
    .rst_n (maqhm_reset),
    .inc   (m_inc),
    .load  (1'b0),
    .lsd   (maqhm_mLsd),
    .msd   (maqhm_mMsd),
    .wrap  (m_wrap)
  );

  maq_bcd2 #(
    .MSD_W   (2),
`ifdef MAQHM_12H_EN
    .MAX_VAL (H12_MAX),
    .MIN_VAL (H12_MIN),
`else
    .MAX_VAL (H24_MAX),
    .MIN_VAL (0),
`endif
    .RST_VAL (RST_H)
  ) u_hour (
    .clk   (maqhm_clock),
    .rst_n (maqhm_reset),
    .inc   (h_inc),
    .load  (1'b0),
    .lsd   (maqhm_hLsd),
    .msd   (maqhm_hMsd),
    .wrap  (h_wrap)
  );

`ifdef MAQHM_12H_EN
  localparam logic [7:0] PM_B = to_bcd(H12_PM);
  logic pm_q;
  logic pm_flip;

  // am/pm flips when the hour steps 11 -> 12; the 12 -> 01 wrap leaves it alone.
  assign pm_flip = h_inc && (maqhm_hMsd == PM_B[5:4]) && (maqhm_hLsd == PM_B[3:0]);
  // A new day starts when pm drops back to am during normal running.
  assign day_ev  = run && pm_flip && pm_q && !h_wrap;
  assign maqhm_pm = pm_q;

  always_ff @(posedge maqhm_clock or negedge maqhm_reset) begin
    if (!maqhm_reset) begin
      pm_q <= 1'b0;
    end else if (pm_flip) begin
      pm_q <= !pm_q;
    end
  end
`else
  assign day_ev = run && h_wrap;
`endif

  assign maqhm_state = state;

  always_ff @(posedge maqhm_clock or negedge maqhm_reset) begin
    if (!maqhm_reset) begin
      state         <= ST_RUN;
      add_q         <= 1'b0;
      day_q         <= 1'b0;
      maqhm_zerosec <= 1'b0;
      maqhm_addday  <= 1'b0;
    end else begin
      add_q         <= maqhm_addminuto;
      day_q         <= day_ev;
      maqhm_addday  <= day_q;
      maqhm_zerosec <= 1'b0;
      case (state)
        ST_SET_H: if (maqhm_mode) state <= ST_SET_M;
        ST_SET_M: begin
          if (maqhm_mode) begin
            state         <= ST_RUN;
            maqhm_zerosec <= 1'b1;
          end
        end
        default:  state <= maqhm_mode ? ST_SET_H : ST_RUN;
      endcase
    end
  end

endmodule
